// File: rtl/cpu_run_monitor_pkg.sv
// Shared encodings for the core run monitor: status/state codes, tohost default and pass code.
package cpu_run_monitor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_RUN     = 3'd2,
        ST_PASS    = 3'd3,
        ST_FAIL    = 3'd4,
        ST_TIMEOUT = 3'd5,
        ST_HANG    = 3'd6
    } run_state_e;

    localparam logic [31:0] TOHOST_DEFAULT = 32'h0000_03FC;
    localparam logic [31:0] PASS_CODE      = 32'd1;

    function automatic logic is_terminal(input run_state_e s);
        return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT) || (s == ST_HANG);
    endfunction

endpackage

// File: rtl/cpu_run_monitor_stall.sv
// Tracks the previous PC during RUN; flags retirements and a PC that stays put for STALL_LIMIT cycles.
module cpu_run_monitor_stall #(
    parameter int XLEN        = 32,
    parameter int STALL_LIMIT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [XLEN-1:0] pc,
    output logic            retire,
    output logic            hang
);

    localparam int SW = $clog2(STALL_LIMIT);

    logic [XLEN-1:0] prev_pc;
    logic            has_prev;
    logic [SW-1:0]   stall_cnt;
    logic            same;

    // the first RUN cycle has nothing to compare against, so it is neither a stall nor a retire
    assign same   = has_prev && (pc == prev_pc);
    assign retire = en && has_prev && (pc != prev_pc);
    assign hang   = en && same && (stall_cnt == SW'(STALL_LIMIT - 2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_pc   <= '0;
            has_prev  <= 1'b0;
            stall_cnt <= '0;
        end else if (clr) begin
            has_prev  <= 1'b0;
            stall_cnt <= '0;
        end else if (en) begin
            prev_pc  <= pc;
            has_prev <= 1'b1;
            if (same)
                stall_cnt <= (stall_cnt == '1) ? stall_cnt : stall_cnt + 1'b1;
            else
                stall_cnt <= '0;
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller for the single-cycle core: core reset sequencing, cycle budget, tohost and hang detection.
// state | meaning: IDLE wait start; RESET core held; RUN core executing; PASS/FAIL/TIMEOUT/HANG terminal
module cpu_run_monitor
    import cpu_run_monitor_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              RST_CYCLES  = 4,
    parameter int              MAX_CYCLES  = 210,
    parameter int              STALL_LIMIT = 16,
    parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(TOHOST_DEFAULT),
    parameter int              CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             core_rst_n,
    input  logic [XLEN-1:0]  pc,
    input  logic             mem_we,
    input  logic [XLEN-1:0]  mem_addr,
    input  logic [XLEN-1:0]  mem_wdata,
    output logic             busy,
    output logic             done,
    output logic [2:0]       status,
    output logic [XLEN-1:0]  exit_code,
    output logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] retired
);

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_e       state, state_nx;
    logic [RST_W-1:0] rst_cnt;
    logic             run, launch, tohost_hit, budget_done, retire, hang;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign run         = (state == ST_RUN);
    assign launch      = start && (state != ST_RESET) && (state != ST_RUN);
    assign tohost_hit  = run && mem_we && (mem_addr == TOHOST_ADDR);
    assign budget_done = run && (cycles == CNT_W'(MAX_CYCLES - 1));
    assign status      = state;

    cpu_run_monitor_stall #(
        .XLEN        (XLEN),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall (
        .clk    (clk),
        .rst    (rst),
        .clr    (launch),
        .en     (run),
        .pc     (pc),
        .retire (retire),
        .hang   (hang)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_RESET;
            ST_RESET: if (rst_cnt == '0) state_nx = ST_RUN;
            ST_RUN: begin
                if (tohost_hit)
                    state_nx = (mem_wdata == XLEN'(PASS_CODE)) ? ST_PASS : ST_FAIL;
                else if (budget_done)
                    state_nx = ST_TIMEOUT;
                else if (hang)
                    state_nx = ST_HANG;
            end
            default:  if (start) state_nx = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rst_cnt <= '0;
        else if (launch)
            rst_cnt <= RST_W'(RST_CYCLES - 1);
        else if ((state == ST_RESET) && (rst_cnt != '0))
            rst_cnt <= rst_cnt - 1'b1;
    end

    // the terminating edge still counts, so a run ending on cycle N reports N
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles  <= '0;
            retired <= '0;
        end else if (launch) begin
            cycles  <= '0;
            retired <= '0;
        end else if (run) begin
            cycles <= sat_inc(cycles);
            if (retire) retired <= sat_inc(retired);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             exit_code <= '0;
        else if (launch)     exit_code <= '0;
        else if (tohost_hit) exit_code <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            core_rst_n <= (state_nx == ST_RUN);
            busy       <= (state_nx == ST_RESET) || (state_nx == ST_RUN);
            done       <= is_terminal(state_nx);
        end
    end

endmodule
